// File: rtl/seq_det_scheduler.sv
// Round-robin time-share of one serial sequence detector among N bit sources; frame = CLEAR, FRAME_LEN RUN, DRAIN, DONE.
// Hit_valid lands FRAME_LEN+3 cycles after the grant decision; dropping Req[sel] mid-frame aborts with no result.
module seq_det_scheduler #(
  parameter int N         = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  localparam int SW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [N-1:0]     Req,
  input  logic [N-1:0]     Bit_in,
  output logic [N-1:0]     Grant,
  output logic             Det_X,
  output logic             Det_clr,
  input  logic             Det_Y,
  output logic             Hit_valid,
  output logic [SW-1:0]    Hit_src,
  output logic [CNT_W-1:0] Hit_count,
  output logic             Busy
);
  localparam int BW = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [SW-1:0]    ptr_q, sel_q, sel_d;
  logic             found_d;
  logic [SW:0]      rr_idx;
  logic [BW-1:0]    bit_cnt_q;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [N-1:0]     grant_q;
  logic             det_clr_q, hit_valid_q, busy_q;
  logic [SW-1:0]    hit_src_q;
  logic [CNT_W-1:0] hit_count_q;

  // First requester strictly after the last-granted pointer, wrapping modulo N.
  always_comb begin
    sel_d   = ptr_q;
    found_d = 1'b0;
    rr_idx  = '0;
    for (int i = 1; i <= N; i++) begin
      rr_idx = {1'b0, ptr_q} + (SW+1)'(i);
      if (rr_idx >= (SW+1)'(N)) rr_idx = rr_idx - (SW+1)'(N);
      if (!found_d && Req[rr_idx[SW-1:0]]) begin
        found_d = 1'b1;
        sel_d   = rr_idx[SW-1:0];
      end
    end
  end

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (Det_Y && (hit_cnt_q != {CNT_W{1'b1}})) hit_cnt_d = hit_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= SW'(N - 1);
      sel_q       <= '0;
      bit_cnt_q   <= '0;
      hit_cnt_q   <= '0;
      grant_q     <= '0;
      det_clr_q   <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_src_q   <= '0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      det_clr_q   <= 1'b0;
      hit_valid_q <= 1'b0;
      // A source that withdraws mid-frame forfeits its turn.
      if ((state_q inside {S_CLEAR, S_RUN, S_DRAIN}) && !Req[sel_q]) begin
        state_q <= S_IDLE;
        grant_q <= '0;
        busy_q  <= 1'b0;
        ptr_q   <= sel_q;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (found_d) begin
              sel_q     <= sel_d;
              grant_q   <= N'(1) << sel_d;
              bit_cnt_q <= '0;
              hit_cnt_q <= '0;
              det_clr_q <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_CLEAR;
            end
          end
          S_CLEAR: state_q <= S_RUN;
          S_RUN: begin
            hit_cnt_q <= hit_cnt_d;
            bit_cnt_q <= bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(FRAME_LEN - 1)) state_q <= S_DRAIN;
          end
          S_DRAIN: begin
            hit_cnt_q   <= hit_cnt_d;
            grant_q     <= '0;
            ptr_q       <= sel_q;
            hit_valid_q <= 1'b1;
            hit_src_q   <= sel_q;
            hit_count_q <= hit_cnt_d;
            state_q     <= S_DONE;
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign Grant     = grant_q;
  assign Det_X     = (state_q == S_RUN) ? Bit_in[sel_q] : 1'b0;
  assign Det_clr   = det_clr_q;
  assign Hit_valid = hit_valid_q;
  assign Hit_src   = hit_src_q;
  assign Hit_count = hit_count_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: "1001" detector models, frame table with a result scoreboard,
// plus hand sequences for latency, saturation, abort and asynchronous reset.
module tb_seq_det_scheduler;
  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [3:0] Req = '0, Bit_in = '0, Grant;
  logic       Det_X, Det_clr, Det_Y, Hit_valid, Busy;
  logic [1:0] Hit_src;
  logic [3:0] Hit_count;

  logic [3:0] req_s = '0, bit_s = '0, grant_s;
  logic       det_x_s, det_clr_s, det_y_s, hv_s, busy_s;
  logic [1:0] src_s, cnt_s;

  int total = 0, bad = 0, cyc = 0;
  int last_hit_cyc = 0, gap = 0, hit_cyc = 0, grant_cyc = 0;

  typedef struct {logic [1:0] src; logic [3:0] cnt;} exp_t;
  exp_t sb[$];

  typedef struct {logic [3:0] req; logic [7:0] stream; logic [3:0] grant; logic [3:0] cnt; bit gap;} vec_t;
  vec_t tbl[10];

  seq_det_scheduler u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Bit_in(Bit_in), .Grant(Grant), .Det_X(Det_X),
    .Det_clr(Det_clr), .Det_Y(Det_Y), .Hit_valid(Hit_valid), .Hit_src(Hit_src),
    .Hit_count(Hit_count), .Busy(Busy));

  seq_det_scheduler #(.N(4), .FRAME_LEN(16), .CNT_W(2)) u_sat (
    .Clk(Clk), .Rst_n(Rst_n), .Req(req_s), .Bit_in(bit_s), .Grant(grant_s), .Det_X(det_x_s),
    .Det_clr(det_clr_s), .Det_Y(det_y_s), .Hit_valid(hv_s), .Hit_src(src_s),
    .Hit_count(cnt_s), .Busy(busy_s));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Overlapping "1001" Moore detectors with a one-cycle output lag.
  logic [3:0] sh, sh_s;
  logic       dy, dy_s;
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin sh <= '0; dy <= 1'b0; end
    else if (Det_clr) begin sh <= '0; dy <= 1'b0; end
    else begin sh <= {sh[2:0], Det_X}; dy <= ({sh[2:0], Det_X} == 4'b1001); end
  end
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin sh_s <= '0; dy_s <= 1'b0; end
    else if (det_clr_s) begin sh_s <= '0; dy_s <= 1'b0; end
    else begin sh_s <= {sh_s[2:0], det_x_s}; dy_s <= ({sh_s[2:0], det_x_s} == 4'b1001); end
  end
  assign Det_Y   = dy;
  assign det_y_s = dy_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Hit_valid === 1'b1) begin
        gap = cyc - last_hit_cyc;
        last_hit_cyc = cyc;
        hit_cyc = cyc;
        chk("grant_off_at_done", 32'(Grant), 32'd0);
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_hit: got src %0d count %0d, want no strobe", Hit_src, Hit_count);
        end else begin
          e = sb.pop_front();
          chk("hit_src", 32'(Hit_src), 32'(e.src));
          chk("hit_count", 32'(Hit_count), 32'(e.cnt));
        end
      end
    end
  end

  // Called at a falling edge while the scheduler is idle; returns in the IDLE cycle after DONE.
  task automatic run_frame(input logic [3:0] req, input logic [7:0] stream,
                           input logic [3:0] eg, input logic [3:0] ec, input bit cg);
    int n;
    exp_t e;
    Req = req;
    n = 0;
    while (Grant === 4'b0 && n < 40) begin @(negedge Clk); n++; end
    if (Grant === 4'b0) begin
      total++; bad++;
      $display("FAIL grant_timeout: got no grant, want %b", eg);
      Req = '0;
      return;
    end
    grant_cyc = cyc;
    chk("grant", 32'(Grant), 32'(eg));
    chk("det_clr", 32'(Det_clr), 32'd1);
    e.src = oh2idx(eg);
    e.cnt = ec;
    sb.push_back(e);
    for (int b = 0; b < 8; b++) begin @(negedge Clk); Bit_in = stream[b] ? 4'hF : 4'h0; end
    @(negedge Clk);
    Bit_in = '0;
    n = 0;
    while (Grant !== 4'b0 && n < 10) begin @(negedge Clk); n++; end
    chk("grant_release", 32'(Grant), 32'd0);
    @(negedge Clk);
    if (cg) chk("hit_gap", 32'(gap), 32'd12);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Req = '0; Bit_in = '0; req_s = '0; bit_s = '0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    int n, t0;
    tbl[0] = '{4'b1111, 8'h00,        4'b0001, 4'd0, 1'b0};
    tbl[1] = '{4'b1111, 8'h00,        4'b0010, 4'd0, 1'b1};
    tbl[2] = '{4'b1111, 8'h00,        4'b0100, 4'd0, 1'b1};
    tbl[3] = '{4'b1111, 8'h00,        4'b1000, 4'd0, 1'b1};
    tbl[4] = '{4'b1111, 8'h00,        4'b0001, 4'd0, 1'b1};
    tbl[5] = '{4'b0010, 8'b00001001,  4'b0010, 4'd1, 1'b1};
    tbl[6] = '{4'b0110, 8'b01001001,  4'b0100, 4'd2, 1'b1};
    tbl[7] = '{4'b0110, 8'hFF,        4'b0010, 4'd0, 1'b1};
    tbl[8] = '{4'b1001, 8'b10011001,  4'b1000, 4'd2, 1'b1};
    tbl[9] = '{4'b1001, 8'b10010000,  4'b0001, 4'd1, 1'b1};

    repeat (2) @(negedge Clk);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hit_valid", 32'(Hit_valid), 32'd0);
    chk("rst_hit_src", 32'(Hit_src), 32'd0);
    chk("rst_hit_count", 32'(Hit_count), 32'd0);
    chk("rst_det_clr", 32'(Det_clr), 32'd0);
    chk("rst_det_x", 32'(Det_X), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Single frame: latency and held result.
    t0 = cyc;
    run_frame(4'b0001, 8'b10011001, 4'b0001, 4'd2, 1'b0);
    Req = '0;
    chk("lat_grant", 32'(grant_cyc - t0), 32'd1);
    chk("lat_hit", 32'(hit_cyc - t0), 32'd11);
    chk("hold_src", 32'(Hit_src), 32'd0);
    chk("hold_count", 32'(Hit_count), 32'd2);
    chk("strobe_one_cycle", 32'(Hit_valid), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);

    do_reset();
    for (int i = 0; i < 10; i++) run_frame(tbl[i].req, tbl[i].stream, tbl[i].grant, tbl[i].cnt, tbl[i].gap);
    Req = '0;

    // Saturating counter on the long-frame instance.
    req_s = 4'b0001;
    n = 0;
    while (grant_s === 4'b0 && n < 40) begin @(negedge Clk); n++; end
    chk("sat_grant", 32'(grant_s), 32'b0001);
    for (int b = 0; b < 16; b++) begin @(negedge Clk); bit_s = ((b % 3) == 0) ? 4'hF : 4'h0; end
    @(negedge Clk);
    bit_s = '0;
    n = 0;
    while (hv_s !== 1'b1 && n < 10) begin @(negedge Clk); n++; end
    chk("sat_valid", 32'(hv_s), 32'd1);
    chk("sat_count", 32'(cnt_s), 32'd3);
    chk("sat_src", 32'(src_s), 32'd0);
    req_s = '0;

    // Abort: source 0 withdraws in its 4th RUN cycle.
    do_reset();
    Req = 4'b0011;
    n = 0;
    while (Grant === 4'b0 && n < 40) begin @(negedge Clk); n++; end
    chk("abort_grant", 32'(Grant), 32'b0001);
    repeat (4) @(negedge Clk);
    Req = 4'b0010;
    @(negedge Clk);
    chk("abort_grant_off", 32'(Grant), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_no_valid", 32'(Hit_valid), 32'd0);
    run_frame(4'b0010, 8'h00, 4'b0010, 4'd0, 1'b0);
    Req = '0;

    // Asynchronous reset in the middle of RUN.
    do_reset();
    Req = 4'b0100;
    Bit_in = 4'hF;
    n = 0;
    while (Grant === 4'b0 && n < 40) begin @(negedge Clk); n++; end
    chk("arst_grant", 32'(Grant), 32'b0100);
    repeat (3) @(negedge Clk);
    chk("arst_detx_run", 32'(Det_X), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_grant_off", 32'(Grant), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_det_x", 32'(Det_X), 32'd0);
    chk("arst_det_clr", 32'(Det_clr), 32'd0);
    chk("arst_hit_valid", 32'(Hit_valid), 32'd0);
    chk("arst_hit_src", 32'(Hit_src), 32'd0);
    chk("arst_hit_count", 32'(Hit_count), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1; Req = '0; Bit_in = '0;
    @(negedge Clk);
    run_frame(4'b1000, 8'h00, 4'b1000, 4'd0, 1'b0);
    run_frame(4'b1111, 8'h00, 4'b0001, 4'd0, 1'b0);
    Req = '0;

    repeat (20) @(negedge Clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
- Time-shares one external serial sequence detector (inputs X/Clk, output Y) among N serial bit sources.
- Grants the detector to one requester at a time, round-robin, for a fixed frame of FRAME_LEN bits.
- Clears the detector before each frame, muxes the granted source onto X, and counts Y hits.
- Reports a per-frame hit count tagged with the source index. Sits between the bit sources and the shared detector instance.

Parameters:
- N, 4, number of requesters (2..8)
- FRAME_LEN, 8, bits per granted frame (2..255)
- CNT_W, 4, hit counter width (saturating)

Ports:
- Clk  in  1  rising-edge clock shared with the detector
- Rst_n  in  1  asynchronous active-low reset
- Req  in  N  per-source request; level, held for the whole frame
- Bit_in  in  N  per-source serial data bit, one bit per Clk
- Grant  out  N  one-hot grant; all-zero when no source is granted
- Det_X  out  1  serial bit to the detector X input
- Det_clr  out  1  one-cycle synchronous clear to the detector state
- Det_Y  in  1  detector match output (Moore, one-cycle lag after the final pattern bit)
- Hit_valid  out  1  one-cycle result strobe
- Hit_src  out  clog2(N)  source index of the reported frame
- Hit_count  out  CNT_W  Det_Y-high cycles counted in the frame
- Busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, CLEAR, RUN, DRAIN, DONE. The state register, pointer and counters are all flops.
- Reset (Rst_n=0, asynchronous):
  - State returns to IDLE; Grant=0, Det_X=0, Det_clr=0, Hit_valid=0, Hit_src=0, Hit_count=0, Busy=0.
  - Last-grant pointer is set to N-1, so the first grant after reset goes to source 0.
  - Reset asserted mid-frame aborts the frame with no Hit_valid.
- IDLE:
  - If Req is non-zero, select the first set Req bit searching upward from pointer+1, wrapping modulo N.
  - Latch the selected index as sel, set Grant=onehot(sel), clear the bit counter and hit counter, then go to CLEAR.
- CLEAR: exactly 1 cycle. Det_clr=1, Det_X=0, Grant held. Then go to RUN.
- RUN: exactly FRAME_LEN cycles.
  - Det_X = Bit_in[sel] (combinational mux, gated to 0 outside RUN).
  - Bit counter increments each cycle. After the FRAME_LEN-th cycle, go to DRAIN.
- DRAIN: 1 cycle. Det_X=0, Grant held. This captures Det_Y for the final frame bit.
- Hit counting: in every RUN and DRAIN cycle, if Det_Y=1, the hit counter increments, saturating at 2^CNT_W-1.
- DONE: 1 cycle.
  - Hit_valid=1, Hit_src=sel, Hit_count=counter value. Grant=0 and pointer=sel. Then go to IDLE.
  - Hit_src and Hit_count hold their values after the strobe until the next DONE.
- Abort: if Req[sel] drops during CLEAR, RUN or DRAIN:
  - Go to IDLE on the next edge, Grant=0, no Hit_valid.
  - Pointer=sel, so the aborted source loses its turn.
- Latency: Req rises at cycle 0 in IDLE -> CLEAR at cycle 1 -> RUN cycles 2..FRAME_LEN+1 -> DRAIN at FRAME_LEN+2 -> Hit_valid at FRAME_LEN+3. The scheduler is back in IDLE at FRAME_LEN+4, so there is one IDLE cycle between frames.
- Fairness:
  - Newly raised requests are not considered until IDLE.
  - With all N requesting continuously, grants go 0,1,...,N-1,0,... with no source granted twice within N frames.
- Width rules: Hit_src is clog2(N) bits (minimum 1). The bit counter is clog2(FRAME_LEN+1) bits.

Test Plan:
- Reset, then Req=4'b0001, Bit_in[0] stream 1,0,0,1,1,0,0,1; bench detector model flags "1001" -> Grant=0001 from cycle 1; Det_clr pulses at cycle 1; Hit_valid at cycle 11 with Hit_src=0, Hit_count=2; Grant=0 at cycle 11.
- Req=4'b1111 held, all streams 0 -> grants in order 0001,0010,0100,1000,0001; each Hit_count=0; Hit_valid strobes 12 cycles apart.
- Req=4'b0110 after a frame by source 1 -> next grant to source 2, then source 1.
- Stream 1,0,0,1,0,0,1,0,0,1 repeated with FRAME_LEN=16, CNT_W=2 -> Hit_count saturates at 3 and does not wrap.
- Req[sel] dropped at the 4th RUN cycle -> Grant=0 next cycle, no Hit_valid, Busy=0; the following grant goes to the next requester.
- Rst_n pulsed low during RUN -> all outputs 0 immediately (asynchronous); after release, Req=4'b1000 grants source 3 and a new Req=4'b1111 grants source 0 first.
